// File: rtl/cc_miss_ar_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cc_miss_ar_ctrl_if
// Brief    : Miss-request, AR-channel, R-monitor and miss-FIFO bundle for the
//            refill-path miss sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface cc_miss_ar_ctrl_if;
    logic        miss_req_i;
    logic [31:0] miss_addr_i;
    logic        miss_ready_o;

    logic [31:0] mem_araddr_o;
    logic [3:0]  mem_arlen_o;
    logic [2:0]  mem_arsize_o;
    logic [1:0]  mem_arburst_o;
    logic        mem_arvalid_o;
    logic        mem_arready_i;

    logic        mem_rvalid_i;
    logic        mem_rready_i;
    logic        mem_rlast_i;

    logic        miss_addr_fifo_full_i;
    logic        miss_addr_fifo_wren_o;
    logic [31:0] miss_addr_fifo_wdata_o;

    logic        fill_done_o;
    logic [3:0]  outstanding_o;
    logic        proto_err_o;

    // Sequencer view: drives AR, FIFO push and status.
    modport master (
        input  miss_req_i, miss_addr_i, mem_arready_i,
               mem_rvalid_i, mem_rready_i, mem_rlast_i, miss_addr_fifo_full_i,
        output miss_ready_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
               mem_arburst_o, mem_arvalid_o, miss_addr_fifo_wren_o,
               miss_addr_fifo_wdata_o, fill_done_o, outstanding_o, proto_err_o
    );

    // Environment view: lookup stage, memory and FIFO side.
    modport slave (
        output miss_req_i, miss_addr_i, mem_arready_i,
               mem_rvalid_i, mem_rready_i, mem_rlast_i, miss_addr_fifo_full_i,
        input  miss_ready_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
               mem_arburst_o, mem_arvalid_o, miss_addr_fifo_wren_o,
               miss_addr_fifo_wdata_o, fill_done_o, outstanding_o, proto_err_o
    );
endinterface
`default_nettype wire

// File: rtl/cc_miss_ar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cc_miss_ar_ctrl
// Brief    : Accepts line misses, issues one INCR read burst per miss, pushes
//            the line address to the fill FIFO and tracks outstanding bursts.
// Revision : 1.0 - initial release
// ============================================================================
module cc_miss_ar_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int BURST_BEATS     = 8
) (
    input  logic              clk,
    input  logic              rst,
    cc_miss_ar_ctrl_if.master bus
);

    localparam int                  c_BEAT_W    = $clog2(BURST_BEATS) + 1;
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_BEATS - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_SAT  = '1;
    localparam logic [3:0]          c_MAX_OUT   = 4'(MAX_OUTSTANDING);
    localparam logic [31:0]         c_LINE_MASK = 32'hFFFF_FFC0;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        AR_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_araddr;
    logic [31:0]         r_wdata;
    logic                r_wren;
    logic                r_fill_done;
    logic                r_proto_err;
    logic [3:0]          r_outstanding;
    logic [c_BEAT_W-1:0] r_beat_cnt;

    logic                w_ready;
    logic                w_arvalid;
    logic                w_accept;
    logic                w_r_hs;
    logic                w_rlast_hs;
    logic                w_beat_err;
    logic                w_underflow;
    logic [31:0]         w_line_addr;

    assign w_line_addr = bus.miss_addr_i & c_LINE_MASK;
    assign w_accept    = bus.miss_req_i & w_ready;
    assign w_r_hs      = bus.mem_rvalid_i & bus.mem_rready_i;
    assign w_rlast_hs  = w_r_hs & bus.mem_rlast_i;
    assign w_underflow = w_rlast_hs & (r_outstanding == 4'd0);

    // A last beat must land exactly on the final index; a non-last beat may not pass it.
    assign w_beat_err  = w_r_hs & (bus.mem_rlast_i ? (r_beat_cnt != c_LAST_BEAT)
                                                   : (r_beat_cnt >= c_LAST_BEAT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_arvalid   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = ~bus.miss_addr_fifo_full_i & (r_outstanding < c_MAX_OUT);
                if (bus.miss_req_i && w_ready) begin
                    w_state_nxt = AR_WAIT;
                end
            end
            AR_WAIT: begin
                w_arvalid = 1'b1;
                if (bus.mem_arready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_araddr      <= 32'd0;
            r_wdata       <= 32'd0;
            r_wren        <= 1'b0;
            r_fill_done   <= 1'b0;
            r_proto_err   <= 1'b0;
            r_outstanding <= 4'd0;
            r_beat_cnt    <= '0;
        end else begin
            r_wren      <= w_accept;
            r_fill_done <= w_rlast_hs;
            if (w_accept) begin
                r_araddr <= w_line_addr;
                r_wdata  <= w_line_addr;
            end

            // A completion with nothing in flight is dropped, so a simultaneous accept still counts.
            if (w_accept && !(w_rlast_hs && !w_underflow)) begin
                r_outstanding <= r_outstanding + 4'd1;
            end else if (!w_accept && w_rlast_hs && !w_underflow) begin
                r_outstanding <= r_outstanding - 4'd1;
            end

            if (w_r_hs) begin
                if (bus.mem_rlast_i) begin
                    r_beat_cnt <= '0;
                end else if (r_beat_cnt != c_BEAT_SAT) begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end

            if (w_beat_err || w_underflow) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign bus.miss_ready_o           = w_ready;
    assign bus.mem_arvalid_o          = w_arvalid;
    assign bus.mem_araddr_o           = r_araddr;
    assign bus.mem_arlen_o            = 4'(BURST_BEATS - 1);
    assign bus.mem_arsize_o           = 3'b011;
    assign bus.mem_arburst_o          = 2'b01;
    assign bus.miss_addr_fifo_wren_o  = r_wren;
    assign bus.miss_addr_fifo_wdata_o = r_wdata;
    assign bus.fill_done_o            = r_fill_done;
    assign bus.outstanding_o          = r_outstanding;
    assign bus.proto_err_o            = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_cc_miss_ar_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cc_miss_ar_ctrl
// Brief    : Directed scenarios plus randomized traffic against a queue-free
//            behavioural model of the miss sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cc_miss_ar_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    cc_miss_ar_ctrl_if bus();

    cc_miss_ar_ctrl #(
        .MAX_OUTSTANDING (4),
        .BURST_BEATS     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired before test end");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.miss_req_i            = 1'b0;
        bus.miss_addr_i           = 32'd0;
        bus.mem_arready_i         = 1'b1;
        bus.mem_rvalid_i          = 1'b0;
        bus.mem_rready_i          = 1'b0;
        bus.mem_rlast_i           = 1'b0;
        bus.miss_addr_fifo_full_i = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        rst = 1'b0;
    endtask

    // Accept one miss and complete its AR handshake (arready assumed high).
    task automatic issue_miss(input logic [31:0] a);
        bus.miss_req_i  = 1'b1;
        bus.miss_addr_i = a;
        cyc();
        bus.miss_req_i  = 1'b0;
        cyc();
    endtask

    task automatic send_beats(input int n, input int last_at);
        for (int i = 1; i <= n; i++) begin
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rready_i = 1'b1;
            bus.mem_rlast_i  = (i == last_at);
            cyc();
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rready_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        total++;
        if ({bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_addr_fifo_wren_o, bus.miss_addr_fifo_wdata_o,
             bus.fill_done_o, bus.outstanding_o, bus.proto_err_o} !== {1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_regs got av=%b aa=%h we=%b wd=%h fd=%b out=%0d pe=%b exp all zero",
                     bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_addr_fifo_wren_o, bus.miss_addr_fifo_wdata_o,
                     bus.fill_done_o, bus.outstanding_o, bus.proto_err_o);
        end
        total++;
        if (bus.miss_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", bus.miss_ready_o);
        end
        rst = 1'b0;
        bus.miss_addr_fifo_full_i = 1'b1;
        #1;
        total++;
        if (bus.miss_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_full got=%b exp=0", bus.miss_ready_o);
        end
        bus.miss_addr_fifo_full_i = 1'b0;
        #1;
    endtask

    task automatic test_single_miss();
        bus.miss_req_i  = 1'b1;
        bus.miss_addr_i = 32'h0000_1234;
        #1;
        total++;
        if (bus.miss_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL single_ready got=%b exp=1", bus.miss_ready_o);
        end
        cyc();
        total++;
        if ({bus.mem_arvalid_o, bus.mem_araddr_o, bus.mem_arlen_o, bus.mem_arsize_o, bus.mem_arburst_o,
             bus.miss_addr_fifo_wren_o, bus.miss_addr_fifo_wdata_o, bus.outstanding_o} !==
            {1'b1, 32'h0000_1200, 4'd7, 3'b011, 2'b01, 1'b1, 32'h0000_1200, 4'd1}) begin
            bad++;
            $display("FAIL single_ar got av=%b aa=%h len=%0d sz=%b bu=%b we=%b wd=%h out=%0d exp 1 00001200 7 011 01 1 00001200 1",
                     bus.mem_arvalid_o, bus.mem_araddr_o, bus.mem_arlen_o, bus.mem_arsize_o, bus.mem_arburst_o,
                     bus.miss_addr_fifo_wren_o, bus.miss_addr_fifo_wdata_o, bus.outstanding_o);
        end
        bus.miss_req_i = 1'b0;
        cyc();
        total++;
        if ({bus.mem_arvalid_o, bus.miss_addr_fifo_wren_o, bus.miss_ready_o} !== 3'b001) begin
            bad++;
            $display("FAIL single_after_hs got av/we/rdy=%b exp=001",
                     {bus.mem_arvalid_o, bus.miss_addr_fifo_wren_o, bus.miss_ready_o});
        end
        send_beats(7, 0);
        total++;
        if ({bus.fill_done_o, bus.outstanding_o} !== {1'b0, 4'd1}) begin
            bad++;
            $display("FAIL single_mid_burst got fd=%b out=%0d exp fd=0 out=1", bus.fill_done_o, bus.outstanding_o);
        end
        send_beats(1, 1);
        total++;
        if ({bus.fill_done_o, bus.outstanding_o, bus.proto_err_o} !== {1'b1, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL single_fill got fd=%b out=%0d pe=%b exp 1 0 0",
                     bus.fill_done_o, bus.outstanding_o, bus.proto_err_o);
        end
        cyc();
        total++;
        if (bus.fill_done_o !== 1'b0) begin
            bad++;
            $display("FAIL single_fill_pulse got=%b exp=0", bus.fill_done_o);
        end
    endtask

    task automatic test_ar_backpressure();
        bus.mem_arready_i = 1'b0;
        bus.miss_req_i    = 1'b1;
        bus.miss_addr_i   = 32'hABCD_EF7F;
        cyc();
        bus.miss_req_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_ready_o} !== {1'b1, 32'hABCD_EF40, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold[%0d] got av=%b aa=%h rdy=%b exp 1 abcdef40 0",
                         i, bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_ready_o);
            end
            cyc();
        end
        bus.mem_arready_i = 1'b1;
        cyc();
        total++;
        if ({bus.mem_arvalid_o, bus.miss_ready_o, bus.outstanding_o} !== {1'b0, 1'b1, 4'd1}) begin
            bad++;
            $display("FAIL bp_release got av=%b rdy=%b out=%0d exp 0 1 1",
                     bus.mem_arvalid_o, bus.miss_ready_o, bus.outstanding_o);
        end
        send_beats(8, 8);
    endtask

    task automatic test_outstanding_limit();
        for (int i = 0; i < 4; i++) begin
            issue_miss(32'h0000_0100 + 32'(i * 64));
        end
        #1;
        total++;
        if ({bus.outstanding_o, bus.miss_ready_o} !== {4'd4, 1'b0}) begin
            bad++;
            $display("FAIL limit_full got out=%0d rdy=%b exp 4 0", bus.outstanding_o, bus.miss_ready_o);
        end
        bus.miss_req_i  = 1'b1;
        bus.miss_addr_i = 32'h0000_9000;
        cyc();
        bus.miss_req_i = 1'b0;
        total++;
        if ({bus.miss_addr_fifo_wren_o, bus.mem_arvalid_o, bus.outstanding_o} !== {1'b0, 1'b0, 4'd4}) begin
            bad++;
            $display("FAIL limit_no_accept got we=%b av=%b out=%0d exp 0 0 4",
                     bus.miss_addr_fifo_wren_o, bus.mem_arvalid_o, bus.outstanding_o);
        end
        send_beats(7, 0);
        #1;
        total++;
        if (bus.miss_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL limit_before_last got rdy=%b exp=0", bus.miss_ready_o);
        end
        send_beats(1, 1);
        #1;
        total++;
        if ({bus.miss_ready_o, bus.outstanding_o} !== {1'b1, 4'd3}) begin
            bad++;
            $display("FAIL limit_after_last got rdy=%b out=%0d exp 1 3", bus.miss_ready_o, bus.outstanding_o);
        end
    endtask

    task automatic test_simultaneous();
        send_beats(8, 8);
        send_beats(7, 0);
        bus.miss_req_i   = 1'b1;
        bus.miss_addr_i  = 32'h5555_5555;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rready_i = 1'b1;
        bus.mem_rlast_i  = 1'b1;
        cyc();
        bus.miss_req_i   = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rready_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        total++;
        if ({bus.outstanding_o, bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_addr_fifo_wren_o,
             bus.miss_addr_fifo_wdata_o, bus.fill_done_o} !== {4'd2, 1'b1, 32'h5555_5540, 1'b1, 32'h5555_5540, 1'b1}) begin
            bad++;
            $display("FAIL simul_acc_last got out=%0d av=%b aa=%h we=%b wd=%h fd=%b exp 2 1 55555540 1 55555540 1",
                     bus.outstanding_o, bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_addr_fifo_wren_o,
                     bus.miss_addr_fifo_wdata_o, bus.fill_done_o);
        end
        cyc();
        bus.miss_addr_fifo_full_i = 1'b1;
        bus.miss_req_i            = 1'b1;
        bus.miss_addr_i           = 32'h0000_7000;
        #1;
        total++;
        if (bus.miss_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL fifo_full_ready got=%b exp=0", bus.miss_ready_o);
        end
        cyc();
        total++;
        if ({bus.miss_addr_fifo_wren_o, bus.mem_arvalid_o, bus.outstanding_o} !== {1'b0, 1'b0, 4'd2}) begin
            bad++;
            $display("FAIL fifo_full_no_push got we=%b av=%b out=%0d exp 0 0 2",
                     bus.miss_addr_fifo_wren_o, bus.mem_arvalid_o, bus.outstanding_o);
        end
        bus.miss_addr_fifo_full_i = 1'b0;
        bus.miss_req_i            = 1'b0;
        send_beats(8, 8);
        send_beats(8, 8);
        total++;
        if ({bus.outstanding_o, bus.proto_err_o} !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL simul_drain got out=%0d pe=%b exp 0 0", bus.outstanding_o, bus.proto_err_o);
        end
    endtask

    task automatic test_proto_err();
        pulse_reset();
        issue_miss(32'h0000_0040);
        send_beats(6, 6);
        total++;
        if ({bus.proto_err_o, bus.outstanding_o} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL perr_short got pe=%b out=%0d exp 1 0", bus.proto_err_o, bus.outstanding_o);
        end
        cyc();
        cyc();
        cyc();
        total++;
        if (bus.proto_err_o !== 1'b1) begin
            bad++;
            $display("FAIL perr_sticky got=%b exp=1", bus.proto_err_o);
        end
        pulse_reset();
        issue_miss(32'h0000_0080);
        send_beats(7, 0);
        total++;
        if (bus.proto_err_o !== 1'b0) begin
            bad++;
            $display("FAIL perr_seven_ok got=%b exp=0", bus.proto_err_o);
        end
        send_beats(2, 0);
        total++;
        if (bus.proto_err_o !== 1'b1) begin
            bad++;
            $display("FAIL perr_long got=%b exp=1", bus.proto_err_o);
        end
        pulse_reset();
        send_beats(1, 1);
        total++;
        if ({bus.proto_err_o, bus.outstanding_o, bus.fill_done_o} !== {1'b1, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL perr_underflow got pe=%b out=%0d fd=%b exp 1 0 1",
                     bus.proto_err_o, bus.outstanding_o, bus.fill_done_o);
        end
    endtask

    task automatic test_reset_in_ar_wait();
        pulse_reset();
        issue_miss(32'h0000_0100);
        bus.mem_arready_i = 1'b0;
        bus.miss_req_i    = 1'b1;
        bus.miss_addr_i   = 32'h0000_0200;
        cyc();
        bus.miss_req_i = 1'b0;
        total++;
        if ({bus.mem_arvalid_o, bus.outstanding_o} !== {1'b1, 4'd2}) begin
            bad++;
            $display("FAIL rstw_pre got av=%b out=%0d exp 1 2", bus.mem_arvalid_o, bus.outstanding_o);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if ({bus.mem_arvalid_o, bus.outstanding_o, bus.mem_araddr_o, bus.miss_ready_o} !== {1'b0, 4'd0, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL rstw_post got av=%b out=%0d aa=%h rdy=%b exp 0 0 00000000 1",
                     bus.mem_arvalid_o, bus.outstanding_o, bus.mem_araddr_o, bus.miss_ready_o);
        end
        bus.mem_arready_i = 1'b1;
    endtask

    task automatic test_random();
        bit          m_busy  = 1'b0;
        bit          m_wren  = 1'b0;
        bit          m_fill  = 1'b0;
        bit          m_err   = 1'b0;
        logic [31:0] m_araddr = 32'd0;
        logic [31:0] m_wdata  = 32'd0;
        int          m_out   = 0;
        int          m_beats = 0;
        logic [80:0] got;
        logic [80:0] exp;
        bit          exp_ready;
        bit          acc;
        bit          rl;
        pulse_reset();
        for (int n = 0; n < 1500; n++) begin
            exp = {m_busy, m_araddr, m_wren, m_wdata, m_fill, 4'(m_out), m_err, 4'd7, 3'b011, 2'b01};
            got = {bus.mem_arvalid_o, bus.mem_araddr_o, bus.miss_addr_fifo_wren_o, bus.miss_addr_fifo_wdata_o,
                   bus.fill_done_o, bus.outstanding_o, bus.proto_err_o, bus.mem_arlen_o, bus.mem_arsize_o,
                   bus.mem_arburst_o};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL rand_regs cycle=%0d got=%h exp=%h", n, got, exp);
            end

            bus.miss_req_i            = 1'($urandom_range(0, 1));
            bus.miss_addr_i           = $urandom();
            bus.mem_arready_i         = ($urandom_range(0, 9) < 6);
            bus.miss_addr_fifo_full_i = ($urandom_range(0, 4) == 0);
            if (m_out > 0) begin
                bus.mem_rvalid_i = 1'($urandom_range(0, 1));
                bus.mem_rready_i = ($urandom_range(0, 3) != 0);
                bus.mem_rlast_i  = (m_beats == 7);
            end else begin
                bus.mem_rvalid_i = 1'b0;
                bus.mem_rready_i = 1'b0;
                bus.mem_rlast_i  = 1'b0;
            end
            #1;
            exp_ready = !m_busy && !bus.miss_addr_fifo_full_i && (m_out < 4);
            total++;
            if (bus.miss_ready_o !== exp_ready) begin
                bad++;
                $display("FAIL rand_ready cycle=%0d got=%b exp=%b", n, bus.miss_ready_o, exp_ready);
            end

            acc = bus.miss_req_i && exp_ready;
            rl  = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i;
            if (bus.mem_rvalid_i && bus.mem_rready_i) begin
                if (bus.mem_rlast_i) begin
                    if (m_beats != 7) m_err = 1'b1;
                    m_beats = 0;
                end else begin
                    if (m_beats >= 7) m_err = 1'b1;
                    m_beats++;
                end
            end
            if (rl && m_out == 0) m_err = 1'b1;
            m_out  = m_out + (acc ? 1 : 0) - ((rl && m_out > 0) ? 1 : 0);
            m_wren = acc;
            m_fill = rl;
            if (m_busy && bus.mem_arready_i) m_busy = 1'b0;
            if (acc) begin
                m_busy   = 1'b1;
                m_araddr = {bus.miss_addr_i[31:6], 6'd0};
                m_wdata  = {bus.miss_addr_i[31:6], 6'd0};
            end
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_miss();
        test_ar_backpressure();
        test_outstanding_limit();
        test_simultaneous();
        test_proto_err();
        test_reset_in_ar_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
